// File: rtl/mux_arb_n_1_if.sv
// mux_arb_n_1_if: source-channel and output-slot signals of the N:1 arbitrating mux.
//   in_valid/in_data/in_last : producer request, payload and end-of-packet per channel
//   in_ready                 : per-channel grant (one-hot or zero)
//   out_valid/out_data/out_sel/out_last : registered output slot
//   out_ready                : consumer accept
// master = producers and consumer around the mux, slave = the mux itself.
interface mux_arb_n_1_if #(
  parameter int unsigned WORD_SIZE  = 5,
  parameter int unsigned NUM_INPUTS = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]           in_valid;
  logic [NUM_INPUTS*WORD_SIZE-1:0] in_data;
  logic [NUM_INPUTS-1:0]           in_last;
  logic [NUM_INPUTS-1:0]           in_ready;
  logic                            out_valid;
  logic [WORD_SIZE-1:0]            out_data;
  logic [SEL_W-1:0]                out_sel;
  logic                            out_last;
  logic                            out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/mux_arb_n_1.sv
// mux_arb_n_1: registered N:1 arbitrating multiplexer with a one-entry output slot.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mux_arb_n_1_if.slave -- channel requests in, registered word out
// ARB_MODE 0 = fixed priority (lowest index), 1 = round-robin.
// PKT_MODE 1 = grant held on one channel from its first beat through its in_last beat.
module mux_arb_n_1 #(
  parameter int unsigned WORD_SIZE  = 5,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned PKT_MODE   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arb_n_1_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(NUM_INPUTS);
  localparam int unsigned IDX_W = SEL_W + 1;

  logic                  out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]      out_sel_q,   out_sel_d;
  logic                  out_last_q,  out_last_d;
  logic [SEL_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic                  lock_q,      lock_d;
  logic [SEL_W-1:0]      lock_ch_q,   lock_ch_d;

  logic                  slot_free_c;
  logic [NUM_INPUTS-1:0] req_c;
  logic [IDX_W-1:0]      idx_c;
  logic [SEL_W-1:0]      grant_c;
  logic                  grant_vld_c;
  logic [WORD_SIZE-1:0]  sel_word_c;
  logic                  sel_last_c;

  // Arbitration: restrict requests to the locked channel, then search from 0 or rr_ptr.
  always_comb begin
    slot_free_c = !out_valid_q || bus.out_ready;
    req_c       = bus.in_valid;
    if ((PKT_MODE != 0) && lock_q) begin
      req_c = bus.in_valid & (NUM_INPUTS'(1) << lock_ch_q);
    end
    grant_c     = '0;
    grant_vld_c = 1'b0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx_c = (ARB_MODE != 0) ? IDX_W'(rr_ptr_q) + IDX_W'(k) : IDX_W'(k);
      if (idx_c >= IDX_W'(NUM_INPUTS)) begin
        idx_c = idx_c - IDX_W'(NUM_INPUTS);
      end
      if (!grant_vld_c && req_c[SEL_W'(idx_c)]) begin
        grant_vld_c = 1'b1;
        grant_c     = SEL_W'(idx_c);
      end
    end
    // Reset gating keeps in_ready low while rst_n is asserted even though the slot reads free.
    grant_vld_c = grant_vld_c && slot_free_c && rst_n;
  end

  // Payload of the granted channel.
  always_comb begin
    sel_word_c = '0;
    sel_last_c = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant_c == SEL_W'(i)) begin
        sel_word_c = bus.in_data[i*WORD_SIZE +: WORD_SIZE];
        sel_last_c = bus.in_last[i];
      end
    end
  end

  // Next state: accept into the slot, or drain it; rr_ptr moves only at packet end.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    if (grant_vld_c) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_word_c;
      out_sel_d   = grant_c;
      out_last_d  = (PKT_MODE != 0) && sel_last_c;
      if (PKT_MODE != 0) begin
        lock_d    = !sel_last_c;
        lock_ch_d = grant_c;
      end
      if ((ARB_MODE != 0) && ((PKT_MODE == 0) || sel_last_c)) begin
        rr_ptr_d = (grant_c == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant_c + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign bus.in_ready  = grant_vld_c ? (NUM_INPUTS'(1) << grant_c) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_mux_arb_n_1.sv
// tb_mux_arb_n_1: directed bench for mux_arb_n_1 in three configurations:
// fixed priority, round-robin, and round-robin with packet locking.
module tb_mux_arb_n_1;
  localparam int unsigned W = 5;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  mux_arb_n_1_if #(.WORD_SIZE(W), .NUM_INPUTS(N)) f_if ();
  mux_arb_n_1_if #(.WORD_SIZE(W), .NUM_INPUTS(N)) r_if ();
  mux_arb_n_1_if #(.WORD_SIZE(W), .NUM_INPUTS(N)) p_if ();

  mux_arb_n_1 #(.WORD_SIZE(W), .NUM_INPUTS(N), .ARB_MODE(0), .PKT_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(f_if.slave));
  mux_arb_n_1 #(.WORD_SIZE(W), .NUM_INPUTS(N), .ARB_MODE(1), .PKT_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(r_if.slave));
  mux_arb_n_1 #(.WORD_SIZE(W), .NUM_INPUTS(N), .ARB_MODE(1), .PKT_MODE(1)) u_pk (
    .clk(clk), .rst_n(rst_n), .bus(p_if.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and land on the sampling (falling) edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    f_if.in_valid = '0; f_if.in_data = '0; f_if.in_last = '0; f_if.out_ready = 1'b0;
    r_if.in_valid = '0; r_if.in_data = '0; r_if.in_last = '0; r_if.out_ready = 1'b0;
    p_if.in_valid = '0; p_if.in_data = '0; p_if.in_last = '0; p_if.out_ready = 1'b0;
    f_if.in_valid = 4'hF;

    // Reset state
    #12;
    check("rst_out_valid", 32'(f_if.out_valid), 32'h0);
    check("rst_out_data",  32'(f_if.out_data),  32'h0);
    check("rst_out_sel",   32'(f_if.out_sel),   32'h0);
    check("rst_out_last",  32'(f_if.out_last),  32'h0);
    check("rst_in_ready",  32'(f_if.in_ready),  32'h0);
    check("rst_rr_valid",  32'(r_if.out_valid), 32'h0);
    check("rst_pk_valid",  32'(p_if.out_valid), 32'h0);
    f_if.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed priority: ch1 beats ch3; in_last ignored without packet mode
    f_if.out_ready = 1'b1;
    f_if.in_last   = 4'hF;
    f_if.in_data[1*W +: W] = 5'h11;
    f_if.in_data[3*W +: W] = 5'h13;
    f_if.in_valid  = 4'b1010;
    #1 check("fp_ready_ch1", 32'(f_if.in_ready), 32'h2);
    step();
    check("fp_valid", 32'(f_if.out_valid), 32'h1);
    check("fp_data1", 32'(f_if.out_data),  32'h11);
    check("fp_sel1",  32'(f_if.out_sel),   32'h1);
    check("fp_last0", 32'(f_if.out_last),  32'h0);
    check("fp_ready_hold", 32'(f_if.in_ready), 32'h2);
    f_if.in_valid = 4'b1000;
    #1 check("fp_ready_ch3", 32'(f_if.in_ready), 32'h8);
    step();
    check("fp_data3", 32'(f_if.out_data), 32'h13);
    check("fp_sel3",  32'(f_if.out_sel),  32'h3);
    f_if.in_valid = '0;
    step();
    check("fp_drain_valid", 32'(f_if.out_valid), 32'h0);
    check("fp_drain_hold",  32'(f_if.out_data),  32'h13);

    // Back-pressure: 5'h07 held 3 cycles, then drain and accept together
    f_if.in_last   = '0;
    f_if.out_ready = 1'b0;
    f_if.in_data[0 +: W] = 5'h07;
    f_if.in_valid  = 4'b0001;
    #1 check("bp_ready_empty", 32'(f_if.in_ready), 32'h1);
    step();
    check("bp_valid", 32'(f_if.out_valid), 32'h1);
    check("bp_data",  32'(f_if.out_data),  32'h07);
    f_if.in_data[0 +: W] = 5'h08;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready_blocked", 32'(f_if.in_ready), 32'h0);
      step();
      check("bp_data_stable", 32'(f_if.out_data),  32'h07);
      check("bp_sel_stable",  32'(f_if.out_sel),   32'h0);
      check("bp_valid_held",  32'(f_if.out_valid), 32'h1);
    end
    f_if.out_ready = 1'b1;
    #1 check("bp_ready_drain", 32'(f_if.in_ready), 32'h1);
    step();
    check("bp_new_valid", 32'(f_if.out_valid), 32'h1);
    check("bp_new_data",  32'(f_if.out_data),  32'h08);
    f_if.in_valid = '0;
    step();
    check("bp_empty", 32'(f_if.out_valid), 32'h0);

    // Asynchronous reset while a word is held
    f_if.out_ready = 1'b0;
    f_if.in_data[2*W +: W] = 5'h0A;
    f_if.in_valid = 4'b0100;
    step();
    check("ar_pre_valid", 32'(f_if.out_valid), 32'h1);
    check("ar_pre_data",  32'(f_if.out_data),  32'h0A);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(f_if.out_valid), 32'h0);
    check("ar_data",  32'(f_if.out_data),  32'h0);
    check("ar_sel",   32'(f_if.out_sel),   32'h0);
    check("ar_ready", 32'(f_if.in_ready),  32'h0);
    f_if.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    f_if.out_ready = 1'b1;
    step();
    check("ar_no_beat", 32'(f_if.out_valid), 32'h0);

    // Round-robin: all channels valid -> 0,1,2,3,0
    r_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) r_if.in_data[i*W +: W] = 5'(8'h10 + i);
    r_if.in_valid = 4'hF;
    #1 check("rr_first_ready", 32'(r_if.in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_sel",  32'(r_if.out_sel),  32'(i % 4));
      check("rr_data", 32'(r_if.out_data), 32'(8'h10 + (i % 4)));
    end

    // Wrap: ch2 accepted -> pointer 3; only ch1 valid -> ch1, pointer 2
    r_if.in_valid = 4'b0100;
    #1 check("wr_ready_ch2", 32'(r_if.in_ready), 32'h4);
    step();
    check("wr_sel2", 32'(r_if.out_sel), 32'h2);
    r_if.in_valid = 4'b0010;
    #1 check("wr_ready_ch1", 32'(r_if.in_ready), 32'h2);
    step();
    check("wr_sel1",  32'(r_if.out_sel),  32'h1);
    check("wr_data1", 32'(r_if.out_data), 32'h11);
    r_if.in_valid = 4'hF;
    #1 check("wr_ptr_is_2", 32'(r_if.in_ready), 32'h4);
    step();
    check("wr_sel_after", 32'(r_if.out_sel), 32'h2);
    r_if.in_valid = '0;
    step();

    // Packet lock: ch2 three beats while ch0 waits
    p_if.out_ready = 1'b1;
    p_if.in_data[2*W +: W] = 5'h01;
    p_if.in_valid = 4'b0100;
    #1 check("pk_ready_b1", 32'(p_if.in_ready), 32'h4);
    step();
    check("pk_sel_b1",  32'(p_if.out_sel),  32'h2);
    check("pk_last_b1", 32'(p_if.out_last), 32'h0);
    check("pk_data_b1", 32'(p_if.out_data), 32'h01);
    p_if.in_data[0 +: W]   = 5'h1F;
    p_if.in_last[0]        = 1'b1;
    p_if.in_data[2*W +: W] = 5'h02;
    p_if.in_valid = 4'b0101;
    #1 check("pk_ready_locked", 32'(p_if.in_ready), 32'h4);
    step();
    check("pk_sel_b2",  32'(p_if.out_sel),  32'h2);
    check("pk_last_b2", 32'(p_if.out_last), 32'h0);
    check("pk_data_b2", 32'(p_if.out_data), 32'h02);
    p_if.in_data[2*W +: W] = 5'h03;
    p_if.in_last[2]        = 1'b1;
    #1 check("pk_ready_b3", 32'(p_if.in_ready), 32'h4);
    step();
    check("pk_sel_b3",  32'(p_if.out_sel),  32'h2);
    check("pk_last_b3", 32'(p_if.out_last), 32'h1);
    check("pk_data_b3", 32'(p_if.out_data), 32'h03);
    p_if.in_valid = 4'b0001;
    #1 check("pk_ready_ch0", 32'(p_if.in_ready), 32'h1);
    step();
    check("pk_sel_ch0",  32'(p_if.out_sel),  32'h0);
    check("pk_data_ch0", 32'(p_if.out_data), 32'h1F);
    check("pk_last_ch0", 32'(p_if.out_last), 32'h1);

    // Single-beat packets never lock: pointer 1 -> ch2, then pointer 3 -> ch0
    p_if.in_valid = 4'b0101;
    #1 check("sb_ready_ch2", 32'(p_if.in_ready), 32'h4);
    step();
    check("sb_sel_ch2", 32'(p_if.out_sel), 32'h2);
    #1 check("sb_ready_ch0", 32'(p_if.in_ready), 32'h1);
    step();
    check("sb_sel_ch0", 32'(p_if.out_sel), 32'h0);
    p_if.in_valid = '0;
    step();
    check("pk_empty", 32'(p_if.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
